// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// States, port IDs and the address legality check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Zero-extended address; anything above the word array is rejected.
  function automatic logic access_err(
    input logic [63:0] addr,
    input int unsigned ram_bits
  );
    logic [63:0] hi;
    hi = addr >> (ram_bits + 2);
    return (addr[1:0] != 2'b00) || (hi != 64'd0);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner choice between fetch and load/store requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on conflict, else D wins.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic gnt_valid,
  output logic gnt_port
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_port  = d_req ? PORT_D : PORT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) gnt_port = ~last_grant;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified I/D memory port arbiter, IDLE->ACCESS->RESP per access.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin conflict policy.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned RAM_SIZE_BIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_valid, gnt_port;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  mem_arb_select u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_port   (gnt_port)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      port_q  <= PORT_I;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= PORT_D;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_ack     = 1'b0;
    i_rdata   = '0;
    i_err     = 1'b0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          port_d  = gnt_port;
          if (gnt_port == PORT_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          err_d = access_err(64'(addr_d), RAM_SIZE_BIT);
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = gnt_port;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = '0;
        if (!err_q) begin
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          mem_read  = ~we_q;
          mem_write = we_q;
          if (!we_q) rdata_d = mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (port_q == PORT_D) begin
          d_ack   = 1'b1;
          d_rdata = rdata_q;
          d_err   = err_q;
        end else begin
          i_ack   = 1'b1;
          i_rdata = rdata_q;
          i_err   = err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
